// File: rtl/mux4_arb_pkg.sv
// Shared types and constants for the four-requester round-robin packet arbiter.
package mux4_arb_pkg;

  localparam int NUM_REQ = 4;

  typedef logic [1:0] sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mux4.sv
// Plain four-input multiplexer, WIDTH bits wide.
module mux4 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first asserted request scanning ptr, ptr+1, ... (mod 4).
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  sel_t               ptr,
  output logic               found,
  output sel_t               idx
);

  sel_t cand;

  // Scan from farthest to nearest so the candidate closest to ptr is written last and wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + sel_t'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one valid/ready channel among four requesters.
// Define MUX4_ARB_STATS_EN to add saturating per-requester grant counters on grant_cnt.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in1,
  input  logic [WIDTH-1:0]         in2,
  input  logic [WIDTH-1:0]         in3,
  input  logic [WIDTH-1:0]         in4,
  input  logic [NUM_REQ-1:0]       in_valid,
  input  logic [NUM_REQ-1:0]       in_last,
  output logic [NUM_REQ-1:0]       in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic [NUM_REQ-1:0]       grant,
  output logic [1:0]               sel,
  output logic [NUM_REQ*CNT_W-1:0] grant_cnt
);

  state_t               state_q, state_d;
  sel_t                 sel_q, sel_d;
  sel_t                 rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;

  logic                 pick_found;
  sel_t                 pick_idx;
  logic                 owner_valid;
  logic                 owner_last;

  rr_pick4 u_pick (
    .req   (in_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  mux4 #(.WIDTH(WIDTH)) u_data_mux (
    .d0 (in1), .d1 (in2), .d2 (in3), .d3 (in4),
    .sel (sel_q),
    .y   (out_data)
  );

  mux4 #(.WIDTH(1)) u_valid_mux (
    .d0 (in_valid[0]), .d1 (in_valid[1]), .d2 (in_valid[2]), .d3 (in_valid[3]),
    .sel (sel_q),
    .y   (owner_valid)
  );

  mux4 #(.WIDTH(1)) u_last_mux (
    .d0 (in_last[0]), .d1 (in_last[1]), .d2 (in_last[2]), .d3 (in_last[3]),
    .sel (sel_q),
    .y   (owner_last)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    sel_d     = sel_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    out_valid = 1'b0;
    out_last  = 1'b0;
    in_ready  = '0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d          = BUSY;
          sel_d            = pick_idx;
          grant_d          = '0;
          grant_d[pick_idx] = 1'b1;
        end
      end
      BUSY: begin
        out_valid = owner_valid;
        out_last  = owner_last;
        in_ready  = grant_q & {NUM_REQ{out_ready}};
        // Packet ends on the accepted last beat; the next scan starts just past this owner.
        if (owner_valid && out_ready && owner_last) begin
          state_d  = IDLE;
          rr_ptr_d = sel_q + sel_t'(1);
          grant_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;

`ifdef MUX4_ARB_STATS_EN
  logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                          grant_start;

  assign grant_start = (state_q == IDLE) && pick_found;

  always_comb begin
    cnt_d = cnt_q;
    if (grant_start && (cnt_q[pick_idx] != {CNT_W{1'b1}})) begin
      cnt_d[pick_idx] = cnt_q[pick_idx] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign grant_cnt = cnt_q;
`else
  assign grant_cnt = '0;
`endif

endmodule
